// File: rtl/jt51_serdac.sv
// Serial DAC front-end: converts the 16-bit left/right sums into YM3012-style
// floating-point words and shifts them out LSB-first with per-channel latch strobes.
module jt51_serdac #(
    parameter int PAD = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        sample_stb,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        so,
    output logic        sbit,
    output logic        sh1,
    output logic        sh2,
    output logic        busy,
    output logic        ovr
);

    localparam int WL = PAD + 13;
    localparam int FL = 2 * WL;
    localparam int CW = $clog2(FL);
    localparam logic [CW-1:0] CNT_SH1  = CW'(WL - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);

    typedef enum logic { IDLE, SHIFT } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [FL-1:0] sr;
    logic [FL-1:0] frame_new;

    // Smallest exponent whose window still holds the sign; mantissa is the
    // 10-bit arithmetic shift by e-1 (floor toward minus infinity).
    function automatic logic [12:0] to_float(input logic signed [15:0] lin);
        logic [2:0] e;
        logic [9:0] man;
        e = 3'd7;
        for (int i = 7; i >= 1; i--) begin
            if (((lin >>> (i + 8)) == 16'sd0) || ((lin >>> (i + 8)) == -16'sd1))
                e = 3'(i);
        end
        man = 10'(lin >>> (e - 3'd1));
        return {e, man};
    endfunction

    function automatic logic [WL-1:0] make_word(input logic [15:0] lin);
        return WL'(to_float($signed(lin))) << PAD;
    endfunction

    always_comb begin
        frame_new = {make_word(right), make_word(left)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            so    <= 1'b0;
            sbit  <= 1'b0;
            sh1   <= 1'b0;
            sh2   <= 1'b0;
            busy  <= 1'b0;
            ovr   <= 1'b0;
        end else if (cen) begin
            case (state)
                IDLE: begin
                    so   <= 1'b0;
                    sbit <= 1'b0;
                    sh1  <= 1'b0;
                    sh2  <= 1'b0;
                    cnt  <= '0;
                    if (sample_stb) begin
                        sr    <= frame_new;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sample_stb && cnt != CNT_LAST) begin
                        // Overrun: drop the rest of this frame, no bit on this tick.
                        sr   <= frame_new;
                        cnt  <= '0;
                        ovr  <= 1'b1;
                        so   <= 1'b0;
                        sbit <= 1'b0;
                        sh1  <= 1'b0;
                        sh2  <= 1'b0;
                        busy <= 1'b1;
                    end else begin
                        so   <= sr[0];
                        sbit <= 1'b1;
                        sh1  <= (cnt == CNT_SH1);
                        sh2  <= (cnt == CNT_LAST);
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (sample_stb) begin
                                sr   <= frame_new;
                                busy <= 1'b1;
                            end else begin
                                sr    <= '0;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt  <= cnt + 1'b1;
                            sr   <= sr >> 1;
                            busy <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/jt51_serdac.md
Name: jt51_serdac

Overview:
- Downstream of the channel accumulator. Takes the exact 16-bit signed left/right sums, latched once per sample.
- Converts each sum to the YM3012-style floating format: 10-bit signed mantissa plus 3-bit exponent.
- Serialises both words LSB-first on a single data line, with per-channel latch strobes, for an external floating-point DAC or a codec bridge.
- Runs on the same clk/cen domain as the operator pipeline.

Parameters:
- PAD, 3: number of leading zero pad bits per channel word; word length = PAD+13, fixed at 16 for PAD=3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state advances only when cen=1
- sample_stb  in  1  one-cen pulse; new left/right valid (driven from the accumulator's c1_enters)
- left  in  16  signed left sample
- right  in  16  signed right sample
- so  out  1  serial data
- sbit  out  1  bit-valid strobe: high on every cen tick carrying a frame bit
- sh1  out  1  left-word latch strobe
- sh2  out  1  right-word latch strobe
- busy  out  1  frame in progress
- ovr  out  1  sticky overrun flag

Behaviour:
- Reset values: so=0, sbit=0, sh1=0, sh2=0, busy=0, ovr=0. Bit counter=0, shift register=0, FSM=IDLE.
- All registers update only on clk edges with cen=1. sample_stb is ignored when cen=0.
- Float conversion (combinational, on the capture tick):
  - Exponent e, 1..7, is the smallest value for which lin[15:e+8] are all equal to lin[e+8].
  - For e=7 only bit 15 is involved, so the condition always holds.
  - man = lin[e+8:e-1], a 10-bit arithmetic shift right by e-1, truncated toward minus infinity.
- Channel word, in transmit order: PAD zero bits, man[0..9], e[0..2]. This is 16 bits per channel.
- FSM:
  - IDLE: busy=0, so=0, sbit=0. On sample_stb → capture both words into a 32-bit shift register (left word first) → SHIFT.
  - SHIFT: each cen tick, output the register LSB on so, sbit=1, shift right, increment the 5-bit bit counter.
  - sh1=1 during the tick with counter=15 (last left bit). sh2=1 during counter=31 (last right bit).
  - After counter=31 → IDLE, with counter reset to 0. busy=1 throughout SHIFT.
- Latency: the first frame bit appears on so on the cen tick after the sample_stb tick. The frame spans exactly 32 cen ticks.
- Nominal rate is one sample_stb per 32 cen ticks. The stb arrives on the same tick the counter=31 bit is shifted:
  - This is not an overrun.
  - The last bit and sh2 are still emitted.
  - The next frame is captured and starts on the following tick (back-to-back, busy stays 1).
- sample_stb while in SHIFT with counter<31:
  - Abort the current frame and recapture the new samples.
  - Restart at counter=0 on the next tick.
  - Set ovr=1; it is cleared only by rst.
  - sh1/sh2 are not emitted for the aborted portion.
- rst mid-frame: every state returns to its reset value on that edge. No strobes are emitted until a new sample_stb.
- Outputs are registered: so, sbit, sh1 and sh2 change only on cen edges, with no combinational path from inputs.

Test Plan:
- left=16'h0100, right=16'hFFFF, single stb → left word: e=1, man=10'h100; right: e=1, man=10'h3FF. Serial bits match, sh1 at bit 15, sh2 at bit 31, busy low after 32 ticks.
- left=16'h7FFF, right=16'h8000 → left e=7, man=10'h1FF; right e=7, man=10'h200.
- left=16'd1000, right=-16'd1000 → left e=2, man=10'd500; right e=2, man=-500 (10'h20C).
- Periodic stb every 32 cen ticks with cen at 1-in-3 duty → continuous frames, busy stays 1, ovr=0, no bit emitted on non-cen cycles.
- stb at counter=10 → frame restarts with new data on the next tick, ovr=1. No sh1 from the aborted frame; the flag persists until rst.
- rst asserted at counter=20 → next cycle all outputs 0, FSM IDLE, ovr=0; the next stb starts a clean frame.
